caesar_encryption: RTL and testbench
====================================

// Module: caesar_encryption
// PURPOSE
//  Stream Caesar encryptor, the transmit-side counterpart of caesar_decryption:
//  data_o = data_i + key (mod 2^D_WIDTH). Buffers input in a small FIFO,
//  applies downstream backpressure, latches the key per message, and passes an
//  end-of-message token through unencrypted. Sits between the message source
//  and the channel feeding caesar_decryption.
// PARAMETERS
//  D_WIDTH     8      character width
//  KEY_WIDTH   16     key width; only key[D_WIDTH-1:0] affects the result
//  FIFO_DEPTH  4      input FIFO entries; power of 2, >= 2
//  END_CHAR    8'hFA  end-of-message token, D_WIDTH wide
// PORTS
//  clk          in   1          system clock, all logic on posedge
//  rst_n        in   1          synchronous, active-low reset
//  data_i       in   D_WIDTH    plaintext character
//  valid_i      in   1          data_i qualifier
//  key          in   KEY_WIDTH  shift amount, sampled at message start
//  out_ready_i  in   1          downstream accepts data_o this cycle
//  busy         out  1          high: valid_i is not accepted this cycle
//  err_o        out  1          sticky: a char was offered while busy
//  data_o       out  D_WIDTH    ciphertext character
//  valid_o      out  1          data_o qualifier
//  last_o       out  1          high with valid_o when data_o == END_CHAR
// BEHAVIOUR
//  - Reset: busy=0, err_o=0, data_o=0, valid_o=0, last_o=0. FIFO is emptied,
//    key register is cleared, FSM goes to IDLE. Reset mid-message discards all
//    buffered characters and does not complete the message.
//  - Accept: push when valid_i && !busy. Offer while busy: char dropped, err_o=1.
//  - busy is registered: high when FIFO is full or FSM is in DRAIN. At full, a
//    simultaneous pop does not clear busy until the next cycle.
//  - Push and pop in the same cycle: count unchanged, FIFO order preserved.
//  - Output register: loads the FIFO head when !valid_o || out_ready_i.
//    data_o, valid_o and last_o hold stable while valid_o && !out_ready_i.
//    Transfer completes on valid_o && out_ready_i.
//  - Latency: accept at edge N with FIFO empty and out_ready_i=1 gives
//    valid_o high after edge N+1. Sustained throughput: 1 char/cycle.
//  - Arithmetic: data_o = data + key_q[D_WIDTH-1:0], truncated to D_WIDTH
//    (wrap-around). END_CHAR passes unchanged and is never encrypted.
//  - FSM:
//    IDLE  -> RUN   on first accept; key_q <= key in that cycle.
//    RUN   -> DRAIN when END_CHAR is accepted (pushed).
//    DRAIN -> IDLE  when the END_CHAR output transfer completes.
//    In RUN, changes on key are ignored.
//    In IDLE, an accepted END_CHAR loads key_q and enters DRAIN directly.
//  - Empty FIFO with no push: valid_o drops after the pending output transfers.
// STRUCTURE
//  - Package caesar_pkg: D_WIDTH/KEY_WIDTH defaults, END_CHAR token,
//    FSM state encoding (IDLE/RUN/DRAIN), shared by encryption and decryption.
//  - Sub-module caesar_fifo: synchronous FIFO with push, pop, full, empty and
//    count; FIFO_DEPTH deep, D_WIDTH wide. Top level holds the FSM, key_q,
//    adder, output register and flags.
// TESTING
//  1. Hold rst_n=0 for 3 cycles, then release -> all outputs 0, busy=0.
//  2. key=16'h0003, send 8'h41, out_ready_i=1 -> data_o=8'h44 with valid_o
//     high after edge N+1.
//  3. Wrap-around:
//     key=16'h0010, send 8'hF8 -> data_o=8'h08.
//     key=16'h0105, send 8'h41 -> data_o=8'h46.
//  4. out_ready_i=0, send 6 chars 8'h01..8'h06 with key=1:
//     -> 5 accepted (1 in output register, 4 in FIFO), busy=1 after the 5th.
//     -> 6th dropped, err_o=1.
//     Then out_ready_i=1 -> outputs 8'h02..8'h06 in order; err_o stays 1.
//  5. key=3, send 8'h41. Change key to 7, send 8'h42, then 8'hFA:
//     -> outputs 8'h44, 8'h45, 8'hFA with last_o=1.
//     Next message 8'h41 -> output 8'h48.
//  6. Send 3 chars with out_ready_i=0, then pulse rst_n=0 for 1 cycle
//     -> valid_o=0, busy=0, FIFO empty; next char is encrypted with the new key.

Source files
------------

// File: rtl/caesar_pkg.sv
// Constants and FSM encoding shared by the Caesar encryption/decryption pair.
package caesar_pkg;

  localparam int CAESAR_D_WIDTH    = 8;
  localparam int CAESAR_KEY_WIDTH  = 16;
  localparam int CAESAR_FIFO_DEPTH = 4;

  localparam logic [7:0] CAESAR_END_CHAR = 8'hFA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } caesar_state_t;

endpackage

// File: rtl/caesar_fifo.sv
// Synchronous FIFO, DEPTH x WIDTH, head visible combinationally on o_dat.
// The caller must not push when full or pop when empty.
module caesar_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dat   = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/caesar_encryption.sv
// Stream Caesar encryptor: data_o = data_i + key (mod 2^D_WIDTH), with an input
// FIFO, per-message key latch, and an end-of-message token passed through as-is.
module caesar_encryption
  import caesar_pkg::*;
#(
  parameter int                 D_WIDTH    = CAESAR_D_WIDTH,
  parameter int                 KEY_WIDTH  = CAESAR_KEY_WIDTH,
  parameter int                 FIFO_DEPTH = CAESAR_FIFO_DEPTH,
  parameter logic [D_WIDTH-1:0] END_CHAR   = D_WIDTH'(CAESAR_END_CHAR)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key,
  input  logic                 out_ready_i,
  output logic                 busy,
  output logic                 err_o,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 last_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  caesar_state_t r_state;
  caesar_state_t w_state_nxt;

  logic [D_WIDTH-1:0] r_key;
  logic [D_WIDTH-1:0] r_data;
  logic               r_valid;
  logic               r_last;
  logic               r_tok;
  logic               r_busy;
  logic               r_err;

  logic               w_push;
  logic               w_pop;
  logic               w_load;
  logic               w_full;
  logic               w_empty;
  logic               w_tok_done;
  logic               w_head_end;
  logic               w_in_end;
  logic               w_key_unused;
  logic [D_WIDTH-1:0] w_head;
  logic [D_WIDTH-1:0] w_enc;
  logic [CW-1:0]      w_count;
  logic [CW-1:0]      w_count_nxt;

  caesar_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (D_WIDTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dat   (data_i),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_push      = valid_i && !r_busy && !w_full;
  assign w_load      = !r_valid || out_ready_i;
  assign w_pop       = w_load && !w_empty;
  assign w_in_end    = (data_i == END_CHAR);
  assign w_head_end  = (w_head == END_CHAR);
  assign w_enc       = w_head_end ? w_head : w_head + r_key;
  assign w_tok_done  = r_valid && out_ready_i && r_tok;
  assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);

  // Only the low D_WIDTH key bits can change the result modulo 2^D_WIDTH.
  assign w_key_unused = ^key[KEY_WIDTH-1:D_WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_push) begin
          w_state_nxt = w_in_end ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_push && w_in_end) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_tok_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_key   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_tok   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // The FIFO is always empty in IDLE, so no older char can see the new key.
      if ((r_state == ST_IDLE) && w_push) begin
        r_key <= key[D_WIDTH-1:0];
      end
      if (w_load) begin
        r_valid <= !w_empty;
        if (!w_empty) begin
          r_data <= w_enc;
          r_last <= (w_enc == END_CHAR);
          r_tok  <= w_head_end;
        end else begin
          r_last <= 1'b0;
          r_tok  <= 1'b0;
        end
      end
      r_busy <= (w_count_nxt == CW'(FIFO_DEPTH)) || (w_state_nxt == ST_DRAIN);
      if (valid_i && r_busy) begin
        r_err <= 1'b1;
      end
    end
  end

  assign busy    = r_busy;
  assign err_o   = r_err;
  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign last_o  = r_last;

endmodule

// File: tb/tb_caesar_encryption.sv
// Directed bench for caesar_encryption: expected outputs are queued on send and
// compared in order as each output transfer completes.
module tb_caesar_encryption;

  logic        clk         = 1'b0;
  logic        rst_n       = 1'b0;
  logic [7:0]  data_i      = 8'h00;
  logic        valid_i     = 1'b0;
  logic [15:0] key         = 16'h0000;
  logic        out_ready_i = 1'b0;
  logic        busy;
  logic        err_o;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        last_o;

  int n_chk = 0;
  int n_err = 0;

  logic [8:0] sb_q [$];

  always #5 clk = ~clk;

  caesar_encryption dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .key         (key),
    .out_ready_i (out_ready_i),
    .busy        (busy),
    .err_o       (err_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .last_o      (last_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] exp_d, input logic exp_l);
    data_i  = c;
    valid_i = 1'b1;
    sb_q.push_back({exp_d, exp_l});
    tick();
    valid_i = 1'b0;
  endtask

  task automatic offer(input logic [7:0] c);
    data_i  = c;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while (sb_q.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    chk(tag, 32'(sb_q.size()), 32'h0);
    tick();
    tick();
  endtask

  // Transfer happens on the next rising edge; inputs are stable at the falling edge.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && valid_o && out_ready_i) begin
      n_chk++;
      assert (sb_q.size() != 0) else begin
        n_err++;
        $error("FAIL out_unexpected: observed data %0h last %0b expected no output", data_o, last_o);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("out_data", 32'(data_o), 32'(e[8:1]));
        chk("out_last", 32'(last_o), 32'(e[0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_chk, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_busy",  32'(busy),    32'h0);
    chk("rst_err",   32'(err_o),   32'h0);
    chk("rst_data",  32'(data_o),  32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_last",  32'(last_o),  32'h0);

    // Basic encryption and latency
    out_ready_i = 1'b1;
    key = 16'h0003;
    send(8'h41, 8'h44, 1'b0);
    chk("lat_n_valid", 32'(valid_o), 32'h0);
    tick();
    chk("lat_n1_valid", 32'(valid_o), 32'h1);
    chk("lat_n1_data",  32'(data_o),  32'h44);
    send(8'hFA, 8'hFA, 1'b1);
    chk("drain_busy", 32'(busy), 32'h1);
    wait_drain("t2_drain");
    chk("idle_busy", 32'(busy), 32'h0);

    // Wrap-around, upper key bits ignored
    key = 16'h0010;
    send(8'hF8, 8'h08, 1'b0);
    send(8'hFA, 8'hFA, 1'b1);
    wait_drain("t3a_drain");
    key = 16'h0105;
    send(8'h41, 8'h46, 1'b0);
    send(8'hFA, 8'hFA, 1'b1);
    wait_drain("t3b_drain");

    // Backpressure, full FIFO, drop and sticky error
    out_ready_i = 1'b0;
    key = 16'h0001;
    send(8'h01, 8'h02, 1'b0);
    send(8'h02, 8'h03, 1'b0);
    send(8'h03, 8'h04, 1'b0);
    send(8'h04, 8'h05, 1'b0);
    chk("bp_busy4", 32'(busy), 32'h0);
    send(8'h05, 8'h06, 1'b0);
    chk("bp_busy5", 32'(busy), 32'h1);
    chk("bp_err5",  32'(err_o), 32'h0);
    offer(8'h06);
    chk("bp_err6",   32'(err_o),   32'h1);
    chk("bp_hold_d", 32'(data_o),  32'h02);
    chk("bp_hold_v", 32'(valid_o), 32'h1);
    out_ready_i = 1'b1;
    wait_drain("t4_drain");
    chk("bp_err_sticky", 32'(err_o), 32'h1);
    send(8'hFA, 8'hFA, 1'b1);
    wait_drain("t4_end_drain");

    // Key latched per message
    key = 16'h0003;
    send(8'h41, 8'h44, 1'b0);
    key = 16'h0007;
    send(8'h42, 8'h45, 1'b0);
    send(8'hFA, 8'hFA, 1'b1);
    wait_drain("t5a_drain");
    send(8'h41, 8'h48, 1'b0);
    send(8'hFA, 8'hFA, 1'b1);
    wait_drain("t5b_drain");

    // Reset mid-message discards everything
    out_ready_i = 1'b0;
    key = 16'h0002;
    offer(8'h10);
    offer(8'h11);
    offer(8'h12);
    chk("t6_pre_valid", 32'(valid_o), 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_valid", 32'(valid_o), 32'h0);
    chk("t6_busy",  32'(busy),    32'h0);
    chk("t6_err",   32'(err_o),   32'h0);
    out_ready_i = 1'b1;
    tick();
    tick();
    chk("t6_fifo_empty", 32'(valid_o), 32'h0);
    key = 16'h0005;
    send(8'h20, 8'h25, 1'b0);
    send(8'hFA, 8'hFA, 1'b1);
    wait_drain("t6_drain");

    chk("sb_final", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
